// File: rtl/receptor_comandos_serial_pkg.sv
// Shared constants for the serial command receiver: ASCII command keys,
// axis control codes, receiver FSM encodings and the byte-to-command decoder.
package comandos_pkg;

    localparam logic [7:0] ASCII_W_MIN    = 8'h77;
    localparam logic [7:0] ASCII_W_MAI    = 8'h57;
    localparam logic [7:0] ASCII_S_MIN    = 8'h73;
    localparam logic [7:0] ASCII_S_MAI    = 8'h53;
    localparam logic [7:0] ASCII_D_MIN    = 8'h64;
    localparam logic [7:0] ASCII_D_MAI    = 8'h44;
    localparam logic [7:0] ASCII_A_MIN    = 8'h61;
    localparam logic [7:0] ASCII_A_MAI    = 8'h41;
    localparam logic [7:0] ASCII_ESPACO   = 8'h20;
    localparam logic [7:0] ASCII_C_MIN    = 8'h63;
    localparam logic [7:0] ASCII_C_MAI    = 8'h43;
    localparam logic [7:0] ASCII_P_MIN    = 8'h70;
    localparam logic [7:0] ASCII_P_MAI    = 8'h50;

    localparam logic [1:0] PARADO   = 2'b00;
    localparam logic [1:0] POSITIVO = 2'b01;
    localparam logic [1:0] NEGATIVO = 2'b10;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        INICIO = 2'd1,
        DADOS  = 2'd2,
        PARADA = 2'd3
    } estado_rx_t;

    typedef enum logic [2:0] {
        CMD_INVALIDO,
        CMD_SOBE,
        CMD_DESCE,
        CMD_DIREITA,
        CMD_ESQUERDA,
        CMD_CONFIRMA,
        CMD_PARA
    } comando_t;

    function automatic comando_t decodifica(input logic [7:0] b);
        case (b)
            ASCII_W_MIN, ASCII_W_MAI:               return CMD_SOBE;
            ASCII_S_MIN, ASCII_S_MAI:               return CMD_DESCE;
            ASCII_D_MIN, ASCII_D_MAI:               return CMD_DIREITA;
            ASCII_A_MIN, ASCII_A_MAI:               return CMD_ESQUERDA;
            ASCII_ESPACO, ASCII_C_MIN, ASCII_C_MAI: return CMD_CONFIRMA;
            ASCII_P_MIN, ASCII_P_MAI:               return CMD_PARA;
            default:                                return CMD_INVALIDO;
        endcase
    endfunction

endpackage

// File: rtl/receptor_comandos_serial_if.sv
// Serial line in, drone control and debug signals out; the receiver is the
// slave side, the terminal/simulator/board side is the master.
interface receptor_comandos_serial_if;
    logic       rx;
    logic [1:0] controle_vertical;
    logic [1:0] controle_horizontal;
    logic       confirma;
    logic       byte_valido;
    logic       erro_quadro;
    logic       cmd_invalido;
    logic [7:0] db_ultimo_byte;
    logic [3:0] db_estado_rx;

    modport slave (
        input  rx,
        output controle_vertical, controle_horizontal, confirma,
        output byte_valido, erro_quadro, cmd_invalido,
        output db_ultimo_byte, db_estado_rx
    );

    modport master (
        output rx,
        input  controle_vertical, controle_horizontal, confirma,
        input  byte_valido, erro_quadro, cmd_invalido,
        input  db_ultimo_byte, db_estado_rx
    );
endinterface

// File: rtl/receptor_comandos_serial_uart_rx.sv
// UART 8N1 receiver: rx synchronizer, baud counter, framing FSM and shift
// register; one-cycle pulses for a good byte or a bad stop bit.
module uart_rx_8n1
    import comandos_pkg::*;
#(
    parameter int CICLOS_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dado,
    output logic       byte_valido,
    output logic       erro_quadro,
    output logic [3:0] db_estado
);

    localparam int CNT_W = $clog2(CICLOS_BIT + 1);
    localparam logic [CNT_W-1:0] FIM_BIT  = CNT_W'(CICLOS_BIT - 1);
    localparam logic [CNT_W-1:0] FIM_MEIO = CNT_W'(CICLOS_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] UM       = CNT_W'(1);

    logic [1:0]       sincr;
    logic             rx_s;
    estado_rx_t       estado;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       n_bit;
    logic [7:0]       desloc;

    // Preset to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sincr <= 2'b11;
        end else begin
            sincr <= {sincr[0], rx};
        end
    end

    assign rx_s = sincr[1];

    // NOTE: sequential state uses <= so every flop in this block samples the
    // pre-edge values; blocking '=' here would leak this edge's updates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= OCIOSO;
            cnt         <= '0;
            n_bit       <= '0;
            // NOTE: the shift register is reset as well; it is only 8 flops
            // and keeps db_ultimo_byte free of X after power-up.
            desloc      <= '0;
            dado        <= '0;
            byte_valido <= 1'b0;
            erro_quadro <= 1'b0;
        end else begin
            byte_valido <= 1'b0;
            erro_quadro <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (!rx_s) begin
                        estado <= INICIO;
                        cnt    <= '0;
                        n_bit  <= '0;
                    end
                end
                INICIO: begin
                    if (cnt == FIM_MEIO) begin
                        cnt    <= '0;
                        estado <= rx_s ? OCIOSO : DADOS;
                    end else begin
                        cnt <= cnt + UM;
                    end
                end
                DADOS: begin
                    if (cnt == FIM_BIT) begin
                        cnt    <= '0;
                        desloc <= {rx_s, desloc[7:1]};
                        n_bit  <= n_bit + 3'd1;
                        if (n_bit == 3'd7) begin
                            estado <= PARADA;
                        end
                    end else begin
                        cnt <= cnt + UM;
                    end
                end
                PARADA: begin
                    if (cnt == FIM_BIT) begin
                        cnt    <= '0;
                        estado <= OCIOSO;
                        if (rx_s) begin
                            dado        <= desloc;
                            byte_valido <= 1'b1;
                        end else begin
                            erro_quadro <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + UM;
                    end
                end
            endcase
        end
    end

    assign db_estado = {2'b00, estado};

endmodule

// File: rtl/receptor_comandos_serial.sv
// Serial command receiver top: decodes received bytes into held axis
// commands and a short confirm level for the drone simulator.
module receptor_comandos_serial
    import comandos_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int BAUD            = 115200,
    parameter int HOLD_CICLOS     = 5000000,
    parameter int CONFIRMA_CICLOS = 4
) (
    input logic                        clock,
    input logic                        reset,
    receptor_comandos_serial_if.slave  bus
);

    localparam int CICLOS_BIT = CLK_HZ / BAUD;
    localparam int HOLD_W     = $clog2(HOLD_CICLOS + 1);
    localparam int CONF_W     = $clog2(CONFIRMA_CICLOS + 1);

    localparam logic [HOLD_W-1:0] HOLD_CARGA = HOLD_W'(HOLD_CICLOS);
    localparam logic [HOLD_W-1:0] HOLD_UM    = HOLD_W'(1);
    localparam logic [CONF_W-1:0] CONF_CARGA = CONF_W'(CONFIRMA_CICLOS);
    localparam logic [CONF_W-1:0] CONF_UM    = CONF_W'(1);

    logic [7:0]        dado;
    logic              byte_valido;
    logic              erro_quadro;
    logic [3:0]        db_estado;
    comando_t          comando;

    logic [1:0]        vertical;
    logic [1:0]        horizontal;
    logic [HOLD_W-1:0] timer_v;
    logic [HOLD_W-1:0] timer_h;
    logic [CONF_W-1:0] conf_cnt;
    logic              cmd_invalido;

    uart_rx_8n1 #(.CICLOS_BIT(CICLOS_BIT)) u_rx (
        .clock       (clock),
        .reset       (reset),
        .rx          (bus.rx),
        .dado        (dado),
        .byte_valido (byte_valido),
        .erro_quadro (erro_quadro),
        .db_estado   (db_estado)
    );

    // dado only changes together with byte_valido, so decoding it directly is
    // stable for the edge that consumes the pulse.
    assign comando = decodifica(dado);

    // Decode takes priority over expiry: a reload on the expiry edge keeps the axis on.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vertical <= PARADO;
            timer_v  <= '0;
        end else if (byte_valido && (comando inside {CMD_SOBE, CMD_DESCE})) begin
            vertical <= (comando == CMD_SOBE) ? POSITIVO : NEGATIVO;
            timer_v  <= HOLD_CARGA;
        end else if (byte_valido && comando == CMD_PARA) begin
            vertical <= PARADO;
            timer_v  <= '0;
        end else if (timer_v != '0) begin
            timer_v <= timer_v - HOLD_UM;
            if (timer_v == HOLD_UM) begin
                vertical <= PARADO;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            horizontal <= PARADO;
            timer_h    <= '0;
        end else if (byte_valido && (comando inside {CMD_DIREITA, CMD_ESQUERDA})) begin
            horizontal <= (comando == CMD_DIREITA) ? POSITIVO : NEGATIVO;
            timer_h    <= HOLD_CARGA;
        end else if (byte_valido && comando == CMD_PARA) begin
            horizontal <= PARADO;
            timer_h    <= '0;
        end else if (timer_h != '0) begin
            timer_h <= timer_h - HOLD_UM;
            if (timer_h == HOLD_UM) begin
                horizontal <= PARADO;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conf_cnt     <= '0;
            cmd_invalido <= 1'b0;
        end else begin
            cmd_invalido <= byte_valido && (comando == CMD_INVALIDO);
            if (byte_valido && comando == CMD_CONFIRMA) begin
                conf_cnt <= CONF_CARGA;
            end else if (conf_cnt != '0) begin
                conf_cnt <= conf_cnt - CONF_UM;
            end
        end
    end

    assign bus.controle_vertical   = vertical;
    assign bus.controle_horizontal = horizontal;
    assign bus.confirma            = (conf_cnt != '0);
    assign bus.cmd_invalido        = cmd_invalido;
    assign bus.byte_valido         = byte_valido;
    assign bus.erro_quadro         = erro_quadro;
    assign bus.db_ultimo_byte      = dado;
    assign bus.db_estado_rx        = db_estado;

endmodule

// File: tb/tb_receptor_comandos_serial.sv
// Self-checking bench for receptor_comandos_serial: serial frames in,
// scoreboard of received bytes, per-scenario checks of timing and levels.
module tb_receptor_comandos_serial;

    localparam int CLK_HZ     = 1000;
    localparam int BAUD       = 100;
    localparam int HOLD       = 50;
    localparam int CONF       = 4;
    localparam int CICLOS_BIT = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;

    receptor_comandos_serial_if bus ();

    receptor_comandos_serial #(
        .CLK_HZ          (CLK_HZ),
        .BAUD            (BAUD),
        .HOLD_CICLOS     (HOLD),
        .CONFIRMA_CICLOS (CONF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int n_bv   = 0;
    int n_err  = 0;
    int n_inv  = 0;
    logic [7:0] esperado_q[$];
    logic [7:0] esperado;

    // Scoreboard: every framed byte must match the oldest byte sent with a good stop bit.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.byte_valido) begin
                n_bv++;
                checks++;
                if (esperado_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_extra got %02h expected no byte", bus.db_ultimo_byte);
                end else begin
                    esperado = esperado_q.pop_front();
                    if (bus.db_ultimo_byte !== esperado) begin
                        errors++;
                        $display("FAIL scoreboard_byte got %02h expected %02h", bus.db_ultimo_byte, esperado);
                    end
                end
            end
            if (bus.erro_quadro) n_err++;
            if (bus.cmd_invalido) n_inv++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx = 1'b0;
        repeat (CICLOS_BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CICLOS_BIT) @(negedge clock);
        end
        bus.rx = stop;
        repeat (CICLOS_BIT) @(negedge clock);
        bus.rx = 1'b1;
    endtask

    task automatic wait_bv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (bus.byte_valido === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [1:0] atual(input int sel);
        case (sel)
            0:       return bus.controle_vertical;
            1:       return bus.controle_horizontal;
            default: return {1'b0, bus.confirma};
        endcase
    endfunction

    task automatic measure(input int sel, input logic [1:0] val, output int n);
        n = 0;
        while (n < 200 && atual(sel) === val) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        bus.rx = 1'b1;
        reset  = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.controle_vertical !== 2'b00) begin
            errors++; $display("FAIL reset_vertical got %b expected 00", bus.controle_vertical);
        end
        checks++;
        if (bus.controle_horizontal !== 2'b00) begin
            errors++; $display("FAIL reset_horizontal got %b expected 00", bus.controle_horizontal);
        end
        checks++;
        if ({bus.confirma, bus.byte_valido, bus.erro_quadro, bus.cmd_invalido} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses got %b expected 0000",
                     {bus.confirma, bus.byte_valido, bus.erro_quadro, bus.cmd_invalido});
        end
        checks++;
        if (bus.db_ultimo_byte !== 8'h00) begin
            errors++; $display("FAIL reset_ultimo_byte got %02h expected 00", bus.db_ultimo_byte);
        end
        checks++;
        if (bus.db_estado_rx !== 4'd0) begin
            errors++; $display("FAIL reset_estado got %0d expected 0", bus.db_estado_rx);
        end
        reset = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if (bus.db_estado_rx !== 4'd0) begin
            errors++; $display("FAIL reset_release_estado got %0d expected 0", bus.db_estado_rx);
        end
    endtask

    task automatic test_w();
        bit ok;
        int n;
        esperado_q.push_back(8'h77);
        fork
            send_byte(8'h77, 1'b1);
            begin
                wait_bv(ok);
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL w_timeout got no byte_valido expected pulse");
                end else begin
                    checks++;
                    if (bus.controle_vertical !== 2'b00) begin
                        errors++; $display("FAIL w_early got %b expected 00", bus.controle_vertical);
                    end
                    @(negedge clock);
                    checks++;
                    if (bus.controle_vertical !== 2'b01) begin
                        errors++; $display("FAIL w_latency got %b expected 01", bus.controle_vertical);
                    end
                    measure(0, 2'b01, n);
                    checks++;
                    if (n !== HOLD) begin
                        errors++; $display("FAIL w_hold got %0d cycles expected %0d", n, HOLD);
                    end
                    checks++;
                    if (bus.controle_vertical !== 2'b00) begin
                        errors++; $display("FAIL w_release got %b expected 00", bus.controle_vertical);
                    end
                end
            end
        join
    endtask

    task automatic test_d_a();
        bit ok;
        int n;
        esperado_q.push_back(8'h64);
        esperado_q.push_back(8'h61);
        fork
            begin
                send_byte(8'h64, 1'b1);
                repeat (120 - 10 * CICLOS_BIT) @(negedge clock);
                send_byte(8'h61, 1'b1);
            end
            begin
                wait_bv(ok);
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL d_timeout got no byte_valido expected pulse");
                end else begin
                    @(negedge clock);
                    measure(1, 2'b01, n);
                    checks++;
                    if (n !== HOLD) begin
                        errors++; $display("FAIL d_hold got %0d cycles expected %0d", n, HOLD);
                    end
                    checks++;
                    if (bus.controle_horizontal !== 2'b00 || bus.controle_vertical !== 2'b00) begin
                        errors++;
                        $display("FAIL d_release got h=%b v=%b expected h=00 v=00",
                                 bus.controle_horizontal, bus.controle_vertical);
                    end
                end
                wait_bv(ok);
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL a_timeout got no byte_valido expected pulse");
                end else begin
                    @(negedge clock);
                    measure(1, 2'b10, n);
                    checks++;
                    if (n !== HOLD) begin
                        errors++; $display("FAIL a_hold got %0d cycles expected %0d", n, HOLD);
                    end
                    checks++;
                    if (bus.controle_horizontal !== 2'b00 || bus.controle_vertical !== 2'b00) begin
                        errors++;
                        $display("FAIL a_release got h=%b v=%b expected h=00 v=00",
                                 bus.controle_horizontal, bus.controle_vertical);
                    end
                end
            end
        join
    endtask

    task automatic test_confirm_invalid();
        bit ok;
        int n;
        int inv0;
        esperado_q.push_back(8'h20);
        fork
            send_byte(8'h20, 1'b1);
            begin
                wait_bv(ok);
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL conf_timeout got no byte_valido expected pulse");
                end else begin
                    @(negedge clock);
                    measure(2, 2'b01, n);
                    checks++;
                    if (n !== CONF) begin
                        errors++; $display("FAIL conf_width got %0d cycles expected %0d", n, CONF);
                    end
                end
            end
        join
        inv0 = n_inv;
        esperado_q.push_back(8'h78);
        fork
            send_byte(8'h78, 1'b1);
            begin
                wait_bv(ok);
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL inv_timeout got no byte_valido expected pulse");
                end else begin
                    @(negedge clock);
                    checks++;
                    if (bus.cmd_invalido !== 1'b1) begin
                        errors++; $display("FAIL inv_pulse got %b expected 1", bus.cmd_invalido);
                    end
                    checks++;
                    if ({bus.controle_vertical, bus.controle_horizontal, bus.confirma} !== 5'b0) begin
                        errors++;
                        $display("FAIL inv_controls got %b expected 00000",
                                 {bus.controle_vertical, bus.controle_horizontal, bus.confirma});
                    end
                    @(negedge clock);
                    checks++;
                    if (bus.cmd_invalido !== 1'b0) begin
                        errors++; $display("FAIL inv_width got %b expected 0", bus.cmd_invalido);
                    end
                end
            end
        join
        checks++;
        if (n_inv !== inv0 + 1) begin
            errors++; $display("FAIL inv_count got %0d expected %0d", n_inv, inv0 + 1);
        end
    endtask

    task automatic test_frame_error();
        int bv0;
        int err0;
        bv0  = n_bv;
        err0 = n_err;
        send_byte(8'h73, 1'b0);
        repeat (30) @(negedge clock);
        checks++;
        if (n_err !== err0 + 1) begin
            errors++; $display("FAIL err_pulse got %0d expected %0d", n_err - err0, 1);
        end
        checks++;
        if (n_bv !== bv0) begin
            errors++; $display("FAIL err_no_byte got %0d expected 0", n_bv - bv0);
        end
        checks++;
        if (bus.controle_vertical !== 2'b00 || bus.db_ultimo_byte !== 8'h78) begin
            errors++;
            $display("FAIL err_unchanged got v=%b byte=%02h expected v=00 byte=78",
                     bus.controle_vertical, bus.db_ultimo_byte);
        end
        checks++;
        if (bus.db_estado_rx !== 4'd0) begin
            errors++; $display("FAIL err_estado got %0d expected 0", bus.db_estado_rx);
        end
    endtask

    task automatic test_glitch();
        int pulsos0;
        bit viu_inicio;
        pulsos0 = n_bv + n_err + n_inv;
        viu_inicio = 1'b0;
        bus.rx = 1'b0;
        repeat (3) @(negedge clock);
        bus.rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.db_estado_rx === 4'd1) viu_inicio = 1'b1;
        end
        checks++;
        if (!viu_inicio) begin
            errors++; $display("FAIL glitch_inicio got no INICIO expected state 1 seen");
        end
        checks++;
        if (bus.db_estado_rx !== 4'd0) begin
            errors++; $display("FAIL glitch_estado got %0d expected 0", bus.db_estado_rx);
        end
        checks++;
        if (n_bv + n_err + n_inv !== pulsos0) begin
            errors++; $display("FAIL glitch_pulses got %0d expected %0d", n_bv + n_err + n_inv, pulsos0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] b;
        b = 8'h73;
        esperado_q.push_back(8'h77);
        fork
            send_byte(8'h77, 1'b1);
            begin
                wait_bv(ok);
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL mid_w_timeout got no byte_valido expected pulse");
                end
            end
        join
        bus.rx = 1'b0;
        repeat (CICLOS_BIT) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            bus.rx = b[i];
            repeat (CICLOS_BIT) @(negedge clock);
        end
        checks++;
        if (bus.db_estado_rx !== 4'd2 || bus.controle_vertical !== 2'b01) begin
            errors++;
            $display("FAIL mid_before got estado=%0d v=%b expected estado=2 v=01",
                     bus.db_estado_rx, bus.controle_vertical);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.controle_vertical, bus.controle_horizontal, bus.confirma, bus.db_ultimo_byte,
             bus.db_estado_rx} !== 17'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b h=%b c=%b byte=%02h estado=%0d expected all 0",
                     bus.controle_vertical, bus.controle_horizontal, bus.confirma,
                     bus.db_ultimo_byte, bus.db_estado_rx);
        end
        bus.rx = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        esperado_q.push_back(8'h73);
        fork
            send_byte(8'h73, 1'b1);
            begin
                wait_bv(ok);
                checks++;
                if (!ok) begin
                    errors++; $display("FAIL mid_s_timeout got no byte_valido expected pulse");
                end else begin
                    @(negedge clock);
                    checks++;
                    if (bus.controle_vertical !== 2'b10) begin
                        errors++; $display("FAIL mid_s_vertical got %b expected 10", bus.controle_vertical);
                    end
                end
            end
        join
        repeat (5) @(negedge clock);
        checks++;
        if (esperado_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_left got %0d bytes expected 0", esperado_q.size());
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_w();
        test_d_a();
        test_confirm_invalid();
        test_frame_error();
        test_glitch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/receptor_comandos_serial.md
Name: receptor_comandos_serial

Overview:
- UART 8N1 command receiver: the producing end of the `controle_vertical` / `controle_horizontal` / `confirma` interface that the drone simulator consumes.
- Decodes ASCII keystrokes sent from a PC terminal into 2-bit axis commands and a confirm level pulse.
- Axis commands are held for a programmable time.
- Outputs connect directly to the simulator top's control inputs; debug outputs feed the board displays and LEDs.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate; CICLOS_BIT = CLK_HZ/BAUD (integer division).
- HOLD_CICLOS, 5000000, cycles an axis command stays asserted after its last matching byte (100 ms at 50 MHz).
- CONFIRMA_CICLOS, 4, cycles `confirma` stays high per confirm byte.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clock.
- controle_vertical  output  2  00 parado, 01 sobe, 10 desce; 11 never driven.
- controle_horizontal  output  2  00 parado, 01 direita, 10 esquerda; 11 never driven.
- confirma  output  1  high for CONFIRMA_CICLOS cycles per confirm byte.
- byte_valido  output  1  one-cycle pulse per correctly framed byte.
- erro_quadro  output  1  one-cycle pulse when the stop bit samples 0.
- cmd_invalido  output  1  one-cycle pulse for a framed byte that is not a command.
- db_ultimo_byte  output  8  last correctly framed byte.
- db_estado_rx  output  4  receiver FSM state code.

Behaviour:
- Interface decided: one clock; reset is asynchronous and active-low.
- Reset (reset=0): all outputs 0; hold timers 0; FSM in OCIOSO; rx synchronizer flops preset to 1.
- rx passes through a 2-flop synchronizer before any use.
- FSM states and codes: OCIOSO=0, INICIO=1, DADOS=2, PARADA=3.
- OCIOSO: a synchronized 0 enters INICIO and clears the bit counter.
- INICIO: samples at CICLOS_BIT/2.
  - If rx=1 (glitch), return to OCIOSO.
  - Otherwise go to DADOS.
- DADOS: samples every CICLOS_BIT; 8 bits, LSB first, shifted into a register; after bit 7 go to PARADA.
- PARADA: samples after CICLOS_BIT, then returns to OCIOSO.
  - rx=1: byte accepted; `byte_valido` pulses and `db_ultimo_byte` updates on the same edge.
  - rx=0: `erro_quadro` pulses; byte discarded; no output changes.
- Decode occurs in the cycle after `byte_valido`; outputs change one cycle after that pulse.
  - 'w'/'W' (0x77/0x57): vertical=01, vertical timer = HOLD_CICLOS.
  - 's'/'S' (0x73/0x53): vertical=10, vertical timer reload.
  - 'd'/'D' (0x64/0x44): horizontal=01, horizontal timer reload.
  - 'a'/'A' (0x61/0x41): horizontal=10, horizontal timer reload.
  - ' ' or 'c'/'C' (0x20/0x63/0x43): confirma=1, confirm counter = CONFIRMA_CICLOS.
  - 'p'/'P' (0x70/0x50): both axes 00 and both timers 0 immediately.
  - Any other byte: `cmd_invalido` pulses; no other effect.
- Hold timers:
  - Each timer decrements every cycle while nonzero.
  - When a timer reaches 0, its axis returns to 00 on the same edge.
  - A repeated command reloads the timer with no gap.
  - The opposite command on the same axis replaces the value and reloads.
  - Axes are independent.
- Confirm counter: `confirma` stays high while the counter is nonzero. A new confirm byte while high reloads the counter, producing no new rising edge.
- Timer widths are $clog2(HOLD_CICLOS+1) and $clog2(CONFIRMA_CICLOS+1); no wrap; decrement saturates at 0.
- Decode update and timer expiry on the same edge: decode wins.
- Reset mid-frame: the frame is abandoned; the next frame after release is received normally.
- A byte beginning before the previous hold expires is handled normally; there is no buffering, since byte spacing ≥10·CICLOS_BIT.

Decomposition:
- Package `comandos_pkg`:
  - ASCII command constants.
  - Control codes PARADO=2'b00, POSITIVO=2'b01, NEGATIVO=2'b10.
  - Receiver state encodings.
- Sub-module `uart_rx_8n1`: synchronizer, FSM, baud counter, shift register. Outputs dado[7:0], byte_valido, erro_quadro, db_estado.
- Top contains the decoder, hold timers and confirm counter.

Test Plan:
- Bench uses CLK_HZ=1000, BAUD=100 (CICLOS_BIT=10), HOLD_CICLOS=50, CONFIRMA_CICLOS=4.
- Reset: reset=0 for 3 cycles with rx=1 → all outputs 0, db_estado_rx=0; release → stays OCIOSO.
- Send 'w' (0x77) → byte_valido one pulse, db_ultimo_byte=0x77, controle_vertical=01 next cycle, back to 00 exactly 50 cycles later.
- Send 'd' then 'a' 120 cycles apart → horizontal 01 for 50 cycles, 00, then 10 for 50 cycles; vertical stays 00.
- Send ' ' (0x20) → confirma high exactly 4 cycles. Send 'x' (0x78) → cmd_invalido one pulse, controls unchanged.
- Frame 0x73 with stop bit=0 → erro_quadro pulse, no byte_valido, controle_vertical stays 00.
- Start-bit glitch (rx low 3 cycles) → return to OCIOSO, no pulses.
- Assert reset mid-DADOS while vertical=01 → all outputs 0 at once; the next 's' after release gives vertical=10.
